// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter: the slave modport faces the arbiter,
// and the master modport faces the requesters and the memory model.
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        wr;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        stall;
    logic [NUM_CH-1:0]        done;
    logic [DATA_W-1:0]        rdata;
    logic                     mem_en;
    logic                     mem_wr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;

    modport slave (
        input  req, wr, addr, wdata, mem_rdata,
        output stall, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req, wr, addr, wdata, mem_rdata,
        input  stall, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of a single multicycle memory port (IDLE -> BUSY -> RESP).
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority, highest index wins.
module mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic [CH_W-1:0]     grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_en_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [CH_W-1:0]     win_d;

    logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
    logic [DATA_W-1:0]   ch_wdata [NUM_CH];

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_addr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
            ch_wdata[i] = bus.wdata[i*DATA_W +: DATA_W];
        end
    end

`ifdef ARB_RR_EN
    logic [CH_W-1:0] ptr_q;

    // Search offsets from the far end down so the channel nearest the pointer is written last.
    always_comb begin
        win_d = '0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            if (bus.req[(32'(ptr_q) + k - 1) % NUM_CH]) begin
                win_d = CH_W'((32'(ptr_q) + k - 1) % NUM_CH);
            end
        end
    end
`else
    always_comb begin
        win_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.req[i]) begin
                win_d = CH_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q     <= win_d;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= bus.wr[win_d];
                        mem_addr_q  <= ch_addr[win_d];
                        mem_wdata_q <= ch_wdata[win_d];
                        cnt_q       <= CNT_W'(1);
                        state_q     <= BUSY;
`ifdef ARB_RR_EN
                        if (win_d == CH_W'(NUM_CH - 1)) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= win_d + 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_W'(MEM_LAT)) begin
                        mem_en_q <= 1'b0;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            done_q[i] <= (grant_q == CH_W'(i));
                        end
                        // Writes leave the last read value on rdata.
                        if (!mem_wr_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    done_q  <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall     = bus.req & ~done_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
